// File: rtl/lcd12864_pkg.sv
// Shared definitions for the LCD12864 bus responder: instruction codes,
// character constants, address width and the responder state type.
package lcd12864_pkg;

  localparam int ADDR_W = 6;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_CLEAR,
    ST_BUSY
  } resp_state_t;

  // 0x02 and 0x03 both return home (bit 0 is don't-care on the real part).
  function automatic logic is_home(input logic [7:0] b);
    return b[7:1] == CMD_HOME[7:1];
  endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// LCD parallel bus as seen from the host (master) and the responder (slave).
interface lcd_bus_responder_if;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] dat;
  logic [7:0] dat_out;
  logic       dat_oe;

  modport master (output rs, rw, en, dat, input  dat_out, dat_oe);
  modport slave  (input  rs, rw, en, dat, output dat_out, dat_oe);
endinterface

// File: rtl/lcd_bus_sync.sv
// Two-stage synchroniser for the asynchronous LCD pins plus an en
// falling-edge detector running on stages 2/3.
module lcd_bus_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs,
  input  logic       rw,
  input  logic       en,
  input  logic [7:0] dat,
  output logic       rs_s,
  output logic       rw_s,
  output logic       en_s,
  output logic [7:0] dat_s,
  output logic       en_fall
);

  logic       rs_m, rw_m, en_m, en_d;
  logic [7:0] dat_m;

  // dat is synchronised bit-wise; the host holds it stable across the whole
  // en pulse, so it has long settled by the time the falling edge is seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rs_m  <= 1'b0;
      rw_m  <= 1'b0;
      en_m  <= 1'b0;
      dat_m <= '0;
      rs_s  <= 1'b0;
      rw_s  <= 1'b0;
      en_s  <= 1'b0;
      dat_s <= '0;
      en_d  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, which is what builds a real shift chain.
      rs_m  <= rs;
      rw_m  <= rw;
      en_m  <= en;
      dat_m <= dat;
      rs_s  <= rs_m;
      rw_s  <= rw_m;
      en_s  <= en_m;
      dat_s <= dat_m;
      en_d  <= en_s;
    end
  end

  assign en_fall = en_d & ~en_s;

endmodule

// File: rtl/lcd_bus_responder.sv
// Emulates the LCD12864 controller bus: accepts instruction/data writes,
// drives the character RAM write port and answers status reads.
module lcd_bus_responder
  import lcd12864_pkg::*;
#(
  parameter int BUSY_CYCLES = 3600,
  parameter int CLEAR_HOLD  = 80000
) (
  input  logic              clk,
  input  logic              rst,
  lcd_bus_responder_if.slave bus,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              cmd_valid,
  output logic [7:0]        cmd_code,
  output logic              overrun
);

  localparam int CNT_MAX = (BUSY_CYCLES > CLEAR_HOLD) ? BUSY_CYCLES : CLEAR_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic              rs_s, rw_s, en_s, en_fall;
  logic [7:0]        dat_s;
  resp_state_t       state;
  logic [ADDR_W-1:0] ac;
  logic [ADDR_W-1:0] clr_addr;
  logic [CNT_W-1:0]  cnt;
  logic              rs_q;
  logic [7:0]        byte_q;
  logic              wr_strobe;

  lcd_bus_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rs     (bus.rs),
    .rw     (bus.rw),
    .en     (bus.en),
    .dat    (bus.dat),
    .rs_s   (rs_s),
    .rw_s   (rw_s),
    .en_s   (en_s),
    .dat_s  (dat_s),
    .en_fall(en_fall)
  );

  assign wr_strobe   = en_fall & ~rw_s;
  assign bus.dat_oe  = ~rs_s & rw_s & en_s;
  assign bus.dat_out = {busy, ac, 1'b0};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ac        <= '0;
      clr_addr  <= '0;
      cnt       <= '0;
      rs_q      <= 1'b0;
      byte_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      cmd_valid <= 1'b0;

      // Strobes arriving while busy are dropped; the countdown is untouched.
      if (wr_strobe && state != ST_IDLE) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (wr_strobe) begin
            rs_q   <= rs_s;
            byte_q <= dat_s;
            busy   <= 1'b1;
            state  <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (rs_q) begin
            wr_en   <= 1'b1;
            wr_addr <= ac;
            wr_data <= byte_q;
            ac      <= ac + 1'b1;
            cnt     <= CNT_W'(BUSY_CYCLES - 1);
            state   <= ST_BUSY;
          end else begin
            cmd_valid <= 1'b1;
            cmd_code  <= byte_q;
            if (byte_q == CMD_CLEAR) begin
              clr_addr <= '0;
              state    <= ST_CLEAR;
            end else begin
              if (is_home(byte_q))  ac <= '0;
              else if (byte_q[7])   ac <= byte_q[ADDR_W-1:0];
              cnt   <= CNT_W'(BUSY_CYCLES - 1);
              state <= ST_BUSY;
            end
          end
        end

        ST_CLEAR: begin
          wr_en    <= 1'b1;
          wr_addr  <= clr_addr;
          wr_data  <= ASCII_SPACE;
          clr_addr <= clr_addr + 1'b1;
          // The sweep already used 64 cycles of the clear hold time.
          if (clr_addr == '1) begin
            ac    <= '0;
            cnt   <= CNT_W'(CLEAR_HOLD - 64);
            state <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: stimulus pushes expected RAM writes
// and instruction pulses into a scoreboard that a negedge monitor drains.
module tb_lcd_bus_responder;
  import lcd12864_pkg::*;

  localparam int BUSY_CYCLES = 3600;
  localparam int CLEAR_HOLD  = 300;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic              busy;
  logic              cmd_valid;
  logic [7:0]        cmd_code;
  logic              overrun;

  lcd_bus_responder_if bus ();

  lcd_bus_responder #(
    .BUSY_CYCLES(BUSY_CYCLES),
    .CLEAR_HOLD (CLEAR_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .cmd_valid(cmd_valid),
    .cmd_code (cmd_code),
    .overrun  (overrun)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_wr;
    logic [7:0] a;
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input bit w, input logic [7:0] a, input logic [7:0] d, input int due);
    exp_t e;
    e.is_wr = w;
    e.a     = a;
    e.d     = d;
    e.due   = due;
    sb.push_back(e);
  endfunction

  // Monitor: every output pulse must match the oldest expected event,
  // including the cycle it was due on.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (wr_en) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_wr: got addr=%0d data=%h at cycle %0d, expected none",
                 wr_addr, wr_data, cyc);
      end else begin
        e = sb.pop_front();
        if (!e.is_wr || e.a != {2'b00, wr_addr} || e.d != wr_data || e.due != cyc) begin
          miscompares++;
          $display("FAIL wr_event: got wr addr=%0d data=%h cycle=%0d, expected %s a=%0d d=%h cycle=%0d",
                   wr_addr, wr_data, cyc, e.is_wr ? "wr" : "cmd", e.a, e.d, e.due);
        end
      end
    end
    if (cmd_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_cmd: got code=%h at cycle %0d, expected none", cmd_code, cyc);
      end else begin
        e = sb.pop_front();
        if (e.is_wr || e.d != cmd_code || e.due != cyc) begin
          miscompares++;
          $display("FAIL cmd_event: got cmd code=%h cycle=%0d, expected %s a=%0d d=%h cycle=%0d",
                   cmd_code, cyc, e.is_wr ? "wr" : "cmd", e.a, e.d, e.due);
        end
      end
    end
  end

  // Host write cycle; p returns the cycle count at the en falling edge.
  task automatic strobe(input logic rs_v, input logic [7:0] d, output int p);
    @(negedge clk);
    bus.rs  = rs_v;
    bus.rw  = 1'b0;
    bus.dat = d;
    bus.en  = 1'b1;
    repeat (4) @(negedge clk);
    bus.en = 1'b0;
    p = cyc;
  endtask

  task automatic status_read(input string name, input logic [7:0] exp);
    @(negedge clk);
    bus.rs = 1'b0;
    bus.rw = 1'b1;
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    check({name, "_oe"}, bus.dat_oe, 1);
    check(name, bus.dat_out, exp);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_oe_off"}, bus.dat_oe, 0);
    bus.rw = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    repeat (4) @(negedge clk);
    for (i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (i == budget) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle_timeout: busy still %0b after %0d cycles, expected 0", busy, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},     wr_en, 0);
    check({tag, "_wr_addr"},   wr_addr, 0);
    check({tag, "_wr_data"},   wr_data, 0);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_cmd_code"},  cmd_code, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_overrun"},   overrun, 0);
    check({tag, "_dat_oe"},    bus.dat_oe, 0);
    check({tag, "_dat_out"},   bus.dat_out, 0);
  endtask

  initial begin
    int p, p2, n;
    bus.rs  = 1'b0;
    bus.rw  = 1'b0;
    bus.en  = 1'b0;
    bus.dat = 8'h00;
    rst     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Set-address 0x85 then data 0x41: lands at address 5, ac becomes 6.
    strobe(1'b0, 8'h85, p);
    push(1'b0, 8'h00, 8'h85, p + 4);
    wait_idle(5000);
    strobe(1'b1, 8'h41, p);
    push(1'b1, 8'd5, 8'h41, p + 4);
    repeat (20) @(negedge clk);
    status_read("status_busy_ac6", 8'h8C);
    wait_idle(5000);
    status_read("status_idle_ac6", 8'h0C);

    // ac wrap: 0xBF sets ac=63; two data writes hit 63 then 0.
    strobe(1'b0, 8'hBF, p);
    push(1'b0, 8'h00, 8'hBF, p + 4);
    wait_idle(5000);
    strobe(1'b1, 8'h11, p);
    push(1'b1, 8'd63, 8'h11, p + 4);
    wait_idle(5000);
    strobe(1'b1, 8'h22, p);
    push(1'b1, 8'd0, 8'h22, p + 4);
    wait_idle(5000);
    status_read("status_ac1", 8'h02);
    check("overrun_before", overrun, 0);

    // Overrun: second data strobe 100 clk later is dropped; busy timing kept.
    strobe(1'b1, 8'h55, p);
    push(1'b1, 8'd1, 8'h55, p + 4);
    repeat (96) @(negedge clk);
    strobe(1'b1, 8'h66, p2);
    repeat (5) @(negedge clk);
    check("overrun_set", overrun, 1);
    // DECODE occupies edge p+3..p+4, BUSY counts 3599..0 -> drop at edge p+3604.
    while (cyc < p + 3603) @(negedge clk);
    check("busy_before_fall", busy, 1);
    @(negedge clk);
    check("busy_after_fall", busy, 0);
    status_read("status_ac2", 8'h04);

    // Clear display: 64 space writes, then busy for DECODE+64+(CLEAR_HOLD-63).
    strobe(1'b0, CMD_CLEAR, p);
    push(1'b0, 8'h00, CMD_CLEAR, p + 4);
    for (int k = 0; k < 64; k++) push(1'b1, 8'(k), ASCII_SPACE, p + 5 + k);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
    check("clear_busy_cycles", n, CLEAR_HOLD + 2);
    status_read("status_after_clear", 8'h00);

    // Reset in the middle of a sweep, right after address 20 is written.
    strobe(1'b0, CMD_CLEAR, p);
    push(1'b0, 8'h00, CMD_CLEAR, p + 4);
    for (int k = 0; k <= 20; k++) push(1'b1, 8'(k), ASCII_SPACE, p + 5 + k);
    while (cyc < p + 25) @(negedge clk);
    check("sweep_addr_at_abort", wr_addr, 20);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);

    // After reset ac restarts at 0.
    strobe(1'b1, ASCII_ZERO, p);
    push(1'b1, 8'd0, ASCII_ZERO, p + 4);
    wait_idle(5000);
    status_read("status_after_reset", 8'h02);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
